// File: rtl/decrypting_entity.sv
// rtl/decrypting_entity.sv - ElGamal decryption engine, m = b * a^(p-1-x) mod p
//
// Recovers the plaintext from an ElGamal cryptogram (a, b). It raises a to the
// power e = p-1-x, which avoids an explicit modular inverse, and then multiplies
// the result by b. All arithmetic runs on one serial interleaved modular multiplier.
//
// Optional build macro: DECRYPT_RANGE_CHECK_EN
//   This macro enables operand range checking. When it is defined, any range
//   violation skips the exponentiation, returns m = 0 and raises output_err.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   input_p_tdata/_tvalid     prime modulus p
//   input_x_key_tdata/_tvalid private key x
//   input_a_tdata/_tvalid     cryptogram part a
//   input_b_tdata/_tvalid     cryptogram part b
//   input_tready              high in IDLE; all four operands are taken together
//   output_m_tdata/_tvalid    recovered plaintext, held until output_m_tready
//   output_m_tready           downstream accept
//   output_err                operand range error, qualified by output_m_tvalid

module decrypting_entity #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_p_tdata,
  input  logic            input_p_tvalid,
  input  logic [SIZE-1:0] input_x_key_tdata,
  input  logic            input_x_key_tvalid,
  input  logic [SIZE-1:0] input_a_tdata,
  input  logic            input_a_tvalid,
  input  logic [SIZE-1:0] input_b_tdata,
  input  logic            input_b_tvalid,
  output logic            input_tready,
  output logic [SIZE-1:0] output_m_tdata,
  output logic            output_m_tvalid,
  input  logic            output_m_tready,
  output logic            output_err
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, PREP, SQR, MUL, FINAL, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] p_q, x_q, a_q, b_q, e_q, r_q;
  logic [IW-1:0]   bit_idx;
  logic [IW-1:0]   step;
  logic            loaded;
  logic [SIZE+1:0] acc;
  logic [SIZE-1:0] mq;  // multiplier, scanned MSB-first
  logic [SIZE-1:0] md;  // addend, always the running result r (< p)

  logic            all_valid;
  logic [SIZE-1:0] mul_op;
  logic [SIZE+1:0] p_ext, acc_sum, acc_red1, acc_next;

  assign all_valid = input_p_tvalid & input_x_key_tvalid & input_a_tvalid & input_b_tvalid;

  // The operand that may be >= p (a or b) is the scanned multiplier, and r is
  // the addend. This keeps 2*acc + addend < 3p, so two subtractions are enough
  // and unreduced a/b still yield (a mod p) * r mod p.
  always_comb begin
    mul_op = b_q;
    case (state)
      SQR:     mul_op = r_q;
      MUL:     mul_op = a_q;
      default: mul_op = b_q;
    endcase
  end

  assign p_ext    = {2'b00, p_q};
  assign acc_sum  = {acc[SIZE:0], 1'b0} + (mq[SIZE-1] ? {2'b00, md} : '0);
  assign acc_red1 = (acc_sum >= p_ext) ? (acc_sum - p_ext) : acc_sum;
  assign acc_next = (acc_red1 >= p_ext) ? (acc_red1 - p_ext) : acc_red1;

`ifdef DECRYPT_RANGE_CHECK_EN
  logic range_bad;
  logic err_q;
  logic err_out_q;

  assign range_bad = (p_q < SIZE'(3)) || (x_q == '0) || (x_q > p_q - SIZE'(2)) ||
                     (a_q == '0) || (a_q > p_q - SIZE'(1)) || (b_q > p_q - SIZE'(1));
  assign output_err = err_out_q;
`else
  assign output_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      p_q             <= '0;
      x_q             <= '0;
      a_q             <= '0;
      b_q             <= '0;
      e_q             <= '0;
      r_q             <= '0;
      bit_idx         <= '0;
      step            <= '0;
      loaded          <= 1'b0;
      acc             <= '0;
      mq              <= '0;
      md              <= '0;
      input_tready    <= 1'b0;
      output_m_tdata  <= '0;
      output_m_tvalid <= 1'b0;
`ifdef DECRYPT_RANGE_CHECK_EN
      err_q           <= 1'b0;
      err_out_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (input_tready && all_valid) begin
            p_q          <= input_p_tdata;
            x_q          <= input_x_key_tdata;
            a_q          <= input_a_tdata;
            b_q          <= input_b_tdata;
            input_tready <= 1'b0;
            state        <= PREP;
          end else begin
            input_tready <= 1'b1;
          end
        end

        PREP: begin
          e_q     <= p_q - SIZE'(1) - x_q;
          r_q     <= SIZE'(1);
          bit_idx <= LAST;
          loaded  <= 1'b0;
`ifdef DECRYPT_RANGE_CHECK_EN
          if (range_bad) begin
            r_q   <= '0;
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            state <= SQR;
          end
`else
          state   <= SQR;
`endif
        end

        // Each state runs one modular product: a load cycle, then SIZE steps.
        SQR, MUL, FINAL: begin
          if (!loaded) begin
            acc    <= '0;
            mq     <= mul_op;
            md     <= r_q;
            step   <= '0;
            loaded <= 1'b1;
          end else begin
            acc  <= acc_next;
            mq   <= {mq[SIZE-2:0], 1'b0};
            step <= step + 1'b1;
            if (step == LAST) begin
              r_q    <= acc_next[SIZE-1:0];
              loaded <= 1'b0;
              if (state == SQR) begin
                if (e_q[bit_idx]) begin
                  state <= MUL;
                end else if (bit_idx == '0) begin
                  state <= FINAL;
                end else begin
                  bit_idx <= bit_idx - 1'b1;
                end
              end else if (state == MUL) begin
                if (bit_idx == '0) begin
                  state <= FINAL;
                end else begin
                  bit_idx <= bit_idx - 1'b1;
                  state   <= SQR;
                end
              end else begin
                state <= DONE;
              end
            end
          end
        end

        DONE: begin
          if (!output_m_tvalid) begin
            output_m_tvalid <= 1'b1;
            output_m_tdata  <= r_q;
`ifdef DECRYPT_RANGE_CHECK_EN
            err_out_q       <= err_q;
`endif
          end else if (output_m_tready) begin
            output_m_tvalid <= 1'b0;
            input_tready    <= 1'b1;
            state           <= IDLE;
`ifdef DECRYPT_RANGE_CHECK_EN
            err_q           <= 1'b0;
            err_out_q       <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypting_entity.sv
// tb/tb_decrypting_entity.sv - directed table-driven bench for decrypting_entity

module tb_decrypting_entity;

  localparam int SIZE = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] p_d = '0, x_d = '0, a_d = '0, b_d = '0;
  logic            p_v = 1'b0, x_v = 1'b0, a_v = 1'b0, b_v = 1'b0;
  logic            input_tready;
  logic [SIZE-1:0] output_m_tdata;
  logic            output_m_tvalid;
  logic            output_m_tready = 1'b0;
  logic            output_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decrypting_entity #(.SIZE(SIZE)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_p_tdata      (p_d),
    .input_p_tvalid     (p_v),
    .input_x_key_tdata  (x_d),
    .input_x_key_tvalid (x_v),
    .input_a_tdata      (a_d),
    .input_a_tvalid     (a_v),
    .input_b_tdata      (b_d),
    .input_b_tvalid     (b_v),
    .input_tready       (input_tready),
    .output_m_tdata     (output_m_tdata),
    .output_m_tvalid    (output_m_tvalid),
    .output_m_tready    (output_m_tready),
    .output_err         (output_err)
  );

  typedef struct {
    logic [63:0] p;
    logic [63:0] x;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] m;
    logic        err;
    int          bp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mm(input logic [63:0] x, input logic [63:0] y, input logic [63:0] p);
    logic [127:0] t;
    logic [127:0] r;
    t = {64'd0, x} * {64'd0, y};
    r = t % {64'd0, p};
    return r[63:0];
  endfunction

  function automatic logic [63:0] mexp(input logic [63:0] base, input logic [63:0] e, input logic [63:0] p);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 63; i >= 0; i--) begin
      r = mm(r, r, p);
      if (e[i]) r = mm(r, base, p);
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          cnt;
    int          lat;
    logic [63:0] el;
    logic        stable;
    el  = v.p - 64'd1 - v.x;
    lat = v.err ? 2 : 2 + (SIZE + $countones(el) + 1) * (SIZE + 1);
    cnt = 0;
    while (!input_tready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_in_ready"}, {63'd0, input_tready}, 64'd1);
    p_d = v.p; x_d = v.x; a_d = v.a; b_d = v.b;
    p_v = 1'b1; x_v = 1'b1; a_v = 1'b1; b_v = 1'b1;
    output_m_tready = 1'b0;
    @(posedge clk);
    #1;
    p_v = 1'b0; x_v = 1'b0; a_v = 1'b0; b_v = 1'b0;
    chk({tag, "_busy_ready"}, {63'd0, input_tready}, 64'd0);
    cnt = 0;
    while (!output_m_tvalid && cnt < 10000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'(lat));
    chk({tag, "_data"}, output_m_tdata, v.m);
    chk({tag, "_err"}, {63'd0, output_err}, {63'd0, v.err});
    stable = 1'b1;
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk);
      #1;
      if (!output_m_tvalid || output_m_tdata !== v.m || input_tready !== 1'b0) stable = 1'b0;
    end
    if (v.bp > 0) chk({tag, "_hold"}, {63'd0, stable}, 64'd1);
    @(negedge clk);
    output_m_tready = 1'b1;
    @(posedge clk);
    #1;
    output_m_tready = 1'b0;
    chk({tag, "_tvalid_drop"}, {63'd0, output_m_tvalid}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, input_tready}, 64'd1);
  endtask

  initial begin
    logic [63:0] bp_p, g, xk, k, y, m0;
    logic        ok;

    // Small hand-computed vectors.
    vecs[0] = '{p: 64'd23, x: 64'd6, a: 64'd10, b: 64'd9, m: 64'd13, err: 1'b0, bp: 0};
`ifdef DECRYPT_RANGE_CHECK_EN
    vecs[1] = '{p: 64'd23, x: 64'd22, a: 64'd10, b: 64'd9, m: 64'd0, err: 1'b1, bp: 0};
    vecs[3] = '{p: 64'd23, x: 64'd6, a: 64'd33, b: 64'd9, m: 64'd0, err: 1'b1, bp: 0};
`else
    vecs[1] = '{p: 64'd23, x: 64'd22, a: 64'd10, b: 64'd9, m: 64'd9, err: 1'b0, bp: 0};
    vecs[3] = '{p: 64'd23, x: 64'd6, a: 64'd33, b: 64'd9, m: 64'd13, err: 1'b0, bp: 0};
`endif
    vecs[2] = '{p: 64'd23, x: 64'd6, a: 64'd10, b: 64'd9, m: 64'd13, err: 1'b0, bp: 50};
    vecs[4] = '{p: 64'd11, x: 64'd3, a: 64'd5, b: 64'd7, m: 64'd10, err: 1'b0, bp: 3};

    // The loopback cryptogram comes from a reference ElGamal encryption model.
    bp_p = 64'd18446744073709551557;
    g    = 64'd2;
    xk   = 64'd123456789;
    k    = 64'd987654321;
    m0   = 64'd98154719832413245;
    y    = mexp(g, xk, bp_p);
    vecs[5] = '{p: bp_p, x: xk, a: mexp(g, k, bp_p), b: mm(m0, mexp(y, k, bp_p), bp_p),
                m: m0, err: 1'b0, bp: 0};

    // Reset state.
    #2;
    chk("rst_in_ready", {63'd0, input_tready}, 64'd0);
    chk("rst_tvalid", {63'd0, output_m_tvalid}, 64'd0);
    chk("rst_tdata", output_m_tdata, 64'd0);
    chk("rst_err", {63'd0, output_err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial valids are never captured.
    @(negedge clk);
    p_d = 64'd23; x_d = 64'd6; a_d = 64'd10; b_d = 64'd9;
    p_v = 1'b1; x_v = 1'b1; a_v = 1'b1; b_v = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_tready !== 1'b1 || output_m_tvalid !== 1'b0) ok = 1'b0;
    end
    chk("partial_idle", {63'd0, ok}, 64'd1);
    run_vec(vecs[0], "partial_then_full");

    // Reset in the middle of the squaring phase.
    @(negedge clk);
    p_d = 64'd23; x_d = 64'd6; a_d = 64'd10; b_d = 64'd9;
    p_v = 1'b1; x_v = 1'b1; a_v = 1'b1; b_v = 1'b1;
    @(posedge clk);
    #1;
    p_v = 1'b0; x_v = 1'b0; a_v = 1'b0; b_v = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midop_busy", {63'd0, input_tready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", {63'd0, input_tready}, 64'd0);
    chk("midrst_tvalid", {63'd0, output_m_tvalid}, 64'd0);
    chk("midrst_tdata", output_m_tdata, 64'd0);
    chk("midrst_err", {63'd0, output_err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
